// File: rtl/ber_window_mon.sv
// Windowed BER monitor over a lane's free-running error/word counters; optional stall timeout via BER_WIN_TIMEOUT_EN.
// Result registered 1 cycle after window close; an unaccepted result is overwritten and flagged in OVF.
module ber_window_mon #(
    parameter int WIN_BW   = 32,
    parameter int CLR_CYC  = 4,
    parameter int SETL_CYC = 8,
    parameter int TO_BW    = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [WIN_BW-1:0] i_win_len,
    input  logic [31:0]       i_err_th,
    input  logic [63:0]       i_err_cnt,
    input  logic [57:0]       i_recv_cnt,
    output logic              o_clr_out,
    output logic              o_busy,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [63:0]       o_res_err,
    output logic [57:0]       o_res_recv,
    output logic [15:0]       o_res_idx,
    output logic              o_res_stall,
    output logic              o_ovf,
    output logic              o_alarm
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_BASE,
        S_RUN
    } state_t;

    localparam logic [7:0] CLR_LAST  = 8'(CLR_CYC - 1);
    localparam logic [7:0] SETL_LAST = 8'(SETL_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_cnt;
    logic [WIN_BW-1:0]   r_win_len;
    logic [31:0]         r_err_th;
    logic [63:0]         r_base_err;
    logic [57:0]         r_base_recv;
    logic [15:0]         r_idx;
    logic                r_stop_pend;
    logic                r_res_vld;
    logic [63:0]         r_res_err;
    logic [57:0]         r_res_recv;
    logic [15:0]         r_res_idx;
    logic                r_res_stall;
    logic                r_ovf;
    logic                r_alarm;

    logic [57:0]         w_d_recv;
    logic [63:0]         w_d_err;
    logic                w_len_hit;
    logic                w_to_hit;
    logic                w_close;
    logic                w_clr;
    logic                w_busy;

    // Modular subtraction makes counter wrap transparent.
    assign w_d_recv  = i_recv_cnt - r_base_recv;
    assign w_d_err   = i_err_cnt - r_base_err;
    assign w_len_hit = ({6'b0, w_d_recv} >= 64'(r_win_len));
    assign w_close   = (r_state == S_RUN) && (w_len_hit || w_to_hit);

`ifdef BER_WIN_TIMEOUT_EN
    logic [TO_BW-1:0] r_to_cnt;
    logic [57:0]      r_prev_recv;
    logic             w_recv_same;

    assign w_recv_same = (i_recv_cnt == r_prev_recv);
    assign w_to_hit    = (r_state == S_RUN) && w_recv_same && (r_to_cnt == '1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_to_cnt    <= '0;
            r_prev_recv <= '0;
        end else begin
            r_prev_recv <= i_recv_cnt;
            if ((r_state != S_RUN) || w_close || !w_recv_same || i_start)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_to_hit = 1'b0 & (TO_BW == 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_busy      = (r_state != S_IDLE);
        if (i_start) begin
            w_state_nxt = S_CLEAR;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_IDLE;
                S_CLEAR:  if (r_cnt == CLR_LAST)  w_state_nxt = S_SETTLE;
                S_SETTLE: if (r_cnt == SETL_LAST) w_state_nxt = S_BASE;
                S_BASE:   w_state_nxt = S_RUN;
                S_RUN:    if (w_close && (r_stop_pend || i_stop)) w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
        if (r_state == S_CLEAR) w_clr = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_win_len   <= '0;
            r_err_th    <= '0;
            r_base_err  <= '0;
            r_base_recv <= '0;
            r_idx       <= '0;
            r_stop_pend <= 1'b0;
            r_res_vld   <= 1'b0;
            r_res_err   <= '0;
            r_res_recv  <= '0;
            r_res_idx   <= '0;
            r_res_stall <= 1'b0;
            r_ovf       <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (i_start || (w_state_nxt != r_state)) ? '0 : r_cnt + 8'd1;
            if (i_start) begin
                r_win_len   <= (i_win_len == '0) ? {{(WIN_BW-1){1'b0}}, 1'b1} : i_win_len;
                r_err_th    <= i_err_th;
                r_stop_pend <= 1'b0;
                r_alarm     <= 1'b0;
                r_ovf       <= 1'b0;
                r_res_vld   <= 1'b0;
                r_idx       <= '0;
            end else begin
                if (r_res_vld && i_res_ready)
                    r_res_vld <= 1'b0;
                if (r_state == S_BASE) begin
                    r_base_err  <= i_err_cnt;
                    r_base_recv <= i_recv_cnt;
                    r_idx       <= '0;
                end
                if (r_state == S_RUN) begin
                    if (w_close && (r_stop_pend || i_stop))
                        r_stop_pend <= 1'b0;
                    else if (i_stop)
                        r_stop_pend <= 1'b1;
                end
                // Bases reload with this cycle's counts so the next window starts exactly where this one ended.
                if (w_close) begin
                    r_res_err   <= w_d_err;
                    r_res_recv  <= w_d_recv;
                    r_res_idx   <= r_idx;
                    r_res_stall <= w_to_hit && !w_len_hit;
                    r_res_vld   <= 1'b1;
                    r_base_err  <= i_err_cnt;
                    r_base_recv <= i_recv_cnt;
                    r_idx       <= r_idx + 16'd1;
                    if (r_res_vld && !i_res_ready)
                        r_ovf <= 1'b1;
                    if (w_d_err > {32'b0, r_err_th})
                        r_alarm <= 1'b1;
                end
            end
        end
    end

    assign o_clr_out   = w_clr;
    assign o_busy      = w_busy;
    assign o_res_valid = r_res_vld;
    assign o_res_err   = r_res_err;
    assign o_res_recv  = r_res_recv;
    assign o_res_idx   = r_res_idx;
    assign o_res_stall = r_res_stall;
    assign o_ovf       = r_ovf;
    assign o_alarm     = r_alarm;

endmodule
